// File: rtl/maze_pkg.sv
// Shared constants and types for the 17x17 maze BFS sequencer and its frontier queue.
package maze_pkg;

    localparam int MAZE_WIDTH = 17;
    localparam int DATA_WIDTH = 5;
    localparam int QDEPTH     = 289;
    localparam int CNT_WIDTH  = 9;
    localparam int COORD_BITS = 2 * DATA_WIDTH;

    localparam logic [1:0] RIGHT = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] UP    = 2'd3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
    } coord_t;

    localparam coord_t TARGET = '{x: DATA_WIDTH'(MAZE_WIDTH - 1), y: DATA_WIDTH'(MAZE_WIDTH - 1)};

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        POP,
        EXPAND,
        DONE
    } bfs_state_t;

endpackage

// File: rtl/maze_bfs_fifo.sv
// Circular FIFO of packed coordinates; flush empties it without touching storage.
module maze_bfs_fifo
    import maze_pkg::*;
#(
    parameter int DEPTH = QDEPTH
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [COORD_BITS-1:0] push_data,
    input  logic                  pop,
    output logic [COORD_BITS-1:0] pop_data,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [COORD_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push_ok;
    logic                  pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/maze_bfs_sched.sv
// BFS sequencer: explores the maze from (0,0) toward (16,16), one neighbour per cycle,
// and emits a parent-direction record for every newly discovered cell.
module maze_bfs_sched
    import maze_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] maze_row_addr,
    input  logic [MAZE_WIDTH-1:0] maze_row_data,
    output logic                  par_we,
    output logic [DATA_WIDTH-1:0] par_x,
    output logic [DATA_WIDTH-1:0] par_y,
    output logic [1:0]            par_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [CNT_WIDTH-1:0]  visited_cnt
);

    localparam logic [DATA_WIDTH-1:0] LAST = DATA_WIDTH'(MAZE_WIDTH - 1);

    bfs_state_t            state;
    bfs_state_t            state_next;
    coord_t                cur;
    coord_t                nbr;
    coord_t                q_data;
    coord_t                q_push_data;
    logic [1:0]            dir;
    logic                  nbr_ok;
    logic                  discover;
    logic                  found_r;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_flush;
    logic                  q_empty;
    logic                  q_full;
    logic [MAZE_WIDTH-1:0] visited [MAZE_WIDTH];

    // Neighbour stays equal to cur when it would leave the grid, so indices are always in range.
    always_comb begin
        nbr    = cur;
        nbr_ok = 1'b0;
        case (dir)
            RIGHT: if (cur.y != LAST) begin nbr_ok = 1'b1; nbr.y = cur.y + DATA_WIDTH'(1); end
            DOWN:  if (cur.x != LAST) begin nbr_ok = 1'b1; nbr.x = cur.x + DATA_WIDTH'(1); end
            LEFT:  if (cur.y != '0)   begin nbr_ok = 1'b1; nbr.y = cur.y - DATA_WIDTH'(1); end
            UP:    if (cur.x != '0)   begin nbr_ok = 1'b1; nbr.x = cur.x - DATA_WIDTH'(1); end
            default: ;
        endcase
    end

    assign maze_row_addr = (state == EXPAND && nbr_ok) ? nbr.x : '0;
    assign discover      = (state == EXPAND) && nbr_ok && maze_row_data[nbr.y]
                           && !visited[nbr.x][nbr.y];

    assign par_we  = discover;
    assign par_x   = discover ? nbr.x : '0;
    assign par_y   = discover ? nbr.y : '0;
    assign par_dir = discover ? dir : 2'd0;

    assign busy  = (state == INIT) || (state == POP) || (state == EXPAND);
    assign done  = (state == DONE);
    assign found = (state == DONE) && found_r;

    assign q_flush     = (state == IDLE);
    assign q_push      = ((state == INIT) || discover) && !q_full;
    assign q_push_data = (state == INIT) ? coord_t'('0) : nbr;
    assign q_pop       = (state == POP) && !q_empty;

    maze_bfs_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_data),
        .empty     (q_empty),
        .full      (q_full)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = POP;
            POP:     state_next = (q_empty || q_data == TARGET) ? DONE : EXPAND;
            EXPAND:  if (dir == UP) state_next = POP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur         <= '0;
            dir         <= 2'd0;
            found_r     <= 1'b0;
            visited_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                INIT: begin
                    visited_cnt <= CNT_WIDTH'(1);
                    found_r     <= 1'b0;
                end
                POP: begin
                    dir     <= 2'd0;
                    found_r <= !q_empty && (q_data == TARGET);
                    if (!q_empty) begin
                        cur <= q_data;
                    end
                end
                EXPAND: begin
                    dir <= dir + 2'd1;
                    if (discover) begin
                        visited_cnt <= visited_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A fresh search starts with only the origin marked, whatever its bitmap bit says.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < MAZE_WIDTH; r++) begin
                visited[r] <= '0;
            end
        end else if (state == INIT) begin
            for (int r = 0; r < MAZE_WIDTH; r++) begin
                visited[r] <= (r == 0) ? MAZE_WIDTH'(1) : '0;
            end
        end else if (discover) begin
            visited[nbr.x][nbr.y] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_maze_bfs_sched.sv
// Scoreboard bench for maze_bfs_sched: directed mazes push expected parent/done records,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_maze_bfs_sched;
    import maze_pkg::*;

    typedef struct {
        int x;
        int y;
        int dir;
        int k;
    } par_rec_t;

    typedef struct {
        int found;
        int cnt;
        int k;
        int npar;
        int ntgt;
    } done_rec_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  clear = 1'b0;
    logic [DATA_WIDTH-1:0] maze_row_addr;
    logic [MAZE_WIDTH-1:0] maze_row_data;
    logic                  par_we;
    logic [DATA_WIDTH-1:0] par_x;
    logic [DATA_WIDTH-1:0] par_y;
    logic [1:0]            par_dir;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [CNT_WIDTH-1:0]  visited_cnt;

    logic [MAZE_WIDTH-1:0] maze_mem [MAZE_WIDTH];

    par_rec_t  par_q[$];
    done_rec_t done_q[$];

    int cyc = 0;
    int t0_cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int par_count = 0;
    int tgt_par = 0;
    bit done_seen = 1'b0;
    bit par_strict = 1'b0;

    maze_bfs_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .clear         (clear),
        .maze_row_addr (maze_row_addr),
        .maze_row_data (maze_row_data),
        .par_we        (par_we),
        .par_x         (par_x),
        .par_y         (par_y),
        .par_dir       (par_dir),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .visited_cnt   (visited_cnt)
    );

    assign maze_row_data = (int'(maze_row_addr) < MAZE_WIDTH) ? maze_mem[maze_row_addr] : '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // k is the cycle number relative to the start edge: INIT is cycle 1.
    always @(negedge clk) begin
        int k;
        par_rec_t  pr;
        done_rec_t dr;
        k = cyc - t0_cyc + 1;
        if (par_we === 1'b1) begin
            par_count++;
            if (int'(par_x) == 16 && int'(par_y) == 16) tgt_par++;
            if (par_q.size() > 0) begin
                pr = par_q.pop_front();
                check_output("par_x", int'(par_x), pr.x);
                check_output("par_y", int'(par_y), pr.y);
                check_output("par_dir", int'(par_dir), pr.dir);
                check_output("par_cycle", k, pr.k);
            end else if (par_strict) begin
                check_output("par_we_unexpected", int'(par_we), 0);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() > 0) begin
                dr = done_q.pop_front();
                check_output("found", int'(found), dr.found);
                check_output("visited_cnt", int'(visited_cnt), dr.cnt);
                check_output("done_cycle", k, dr.k);
                check_output("par_count", par_count, dr.npar);
                check_output("target_par_count", tgt_par, dr.ntgt);
            end else begin
                check_output("done_unexpected", int'(done), 0);
            end
            done_seen = 1'b1;
        end
    end

    task automatic set_maze_open();
        for (int r = 0; r < MAZE_WIDTH; r++) maze_mem[r] = '1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"}, int'(busy), 0);
        check_output({tag, "_done"}, int'(done), 0);
        check_output({tag, "_found"}, int'(found), 0);
        check_output({tag, "_par_we"}, int'(par_we), 0);
        check_output({tag, "_par_x"}, int'(par_x), 0);
        check_output({tag, "_par_y"}, int'(par_y), 0);
        check_output({tag, "_par_dir"}, int'(par_dir), 0);
        check_output({tag, "_visited_cnt"}, int'(visited_cnt), 0);
        check_output({tag, "_row_addr"}, int'(maze_row_addr), 0);
    endtask

    task automatic begin_search();
        par_count = 0;
        tgt_par   = 0;
        done_seen = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        t0_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input int e_found, input int e_cnt, input int e_k,
                                  input int e_npar, input int e_ntgt, input bit strict,
                                  input int budget);
        done_rec_t dr;
        dr = '{found: e_found, cnt: e_cnt, k: e_k, npar: e_npar, ntgt: e_ntgt};
        done_q.push_back(dr);
        par_strict = strict;
        begin_search();
        for (int i = 0; i < budget && !done_seen; i++) @(negedge clk);
        check_output("done_seen", int'(done_seen), 1);
        check_output("par_q_drained", par_q.size(), 0);
        if (!done_seen) done_q.delete();
        par_q.delete();
        repeat (2) @(negedge clk);
        check_output("busy_after_done", int'(busy), 0);
        check_output("visited_cnt_held", int'(visited_cnt), e_cnt);
    endtask

    initial begin
        par_rec_t pr;
        set_maze_open();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All-open maze: first discoveries hand-traced, then the whole grid.
        pr = '{x: 0, y: 1, dir: 0, k: 3};  par_q.push_back(pr);
        pr = '{x: 1, y: 0, dir: 1, k: 4};  par_q.push_back(pr);
        pr = '{x: 0, y: 2, dir: 0, k: 8};  par_q.push_back(pr);
        pr = '{x: 1, y: 1, dir: 1, k: 9};  par_q.push_back(pr);
        apply_stimulus(1, 289, 1443, 288, 1, 1'b0, 1600);

        // Origin boxed in by walls at (0,1) and (1,0).
        maze_mem[0] = 17'h1FFFD;
        maze_mem[1] = 17'h1FFFE;
        apply_stimulus(0, 1, 8, 0, 0, 1'b1, 50);

        // Corridor along row 0, then down column 16.
        maze_mem[0] = '1;
        for (int r = 1; r < MAZE_WIDTH; r++) maze_mem[r] = 17'h10000;
        for (int j = 0; j < 16; j++) begin
            pr = '{x: 0, y: j + 1, dir: 0, k: 3 + 5 * j};
            par_q.push_back(pr);
        end
        for (int r = 1; r <= 16; r++) begin
            pr = '{x: r, y: 16, dir: 1, k: 3 + 5 * (15 + r) + 1};
            par_q.push_back(pr);
        end
        apply_stimulus(1, 33, 163, 32, 1, 1'b1, 300);

        // Target cell walled off.
        set_maze_open();
        maze_mem[16] = 17'h0FFFF;
        apply_stimulus(0, 288, 1443, 287, 0, 1'b0, 1600);

        // Abort with clear during cycle 50; 15 cells are discovered by then.
        set_maze_open();
        par_strict = 1'b0;
        begin_search();
        repeat (49) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_output("clear_busy", int'(busy), 0);
        check_output("clear_visited_cnt", int'(visited_cnt), 15);
        repeat (10) @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check_output("clear_start_busy", int'(busy), 0);
        check_output("clear_start_visited_cnt", int'(visited_cnt), 15);
        apply_stimulus(1, 289, 1443, 288, 1, 1'b0, 1600);

        // Reset for one edge during the first EXPAND cycle, with start held high.
        begin_search();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_output("post_reset_busy", int'(busy), 0);
        apply_stimulus(1, 289, 1443, 288, 1, 1'b0, 1600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
